// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg: shared constants, FSM states and config-entry field layout for fan_ctrl
package fan_ctrl_pkg;
  localparam int N        = 32;
  localparam int N_ADDERS = N - 1;
  localparam int SELW     = 6 * N_ADDERS;
  localparam int CFGW     = 2 * N_ADDERS + SELW;
  localparam int N_CFG    = 4;
  localparam int ADD_OFF  = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
  function automatic int byp_off(input int n_adders);
    return n_adders;
  endfunction
  function automatic int sel_off(input int n_adders);
    return 2 * n_adders;
  endfunction
endpackage

// File: rtl/fan_cfg_table.sv
// fan_cfg_table: 4-entry config table, one write port, asynchronous read port
module fan_cfg_table import fan_ctrl_pkg::*; #(
  parameter int W = CFGW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [1:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [1:0]   raddr_i,
  output logic [W-1:0] rdata_o
);
  logic [W-1:0] mem_q [N_CFG];
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '{default: '0};
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  // a write lands at the edge, so a same-cycle reader still sees the old entry
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fan_ctrl.sv
// fan_ctrl: job sequencer for an external reduction tree; two-stage
// valid/ready pipeline around the tree with a per-job latched configuration
module fan_ctrl #(
  parameter int N        = fan_ctrl_pkg::N,
  parameter int DW_DATA  = 8,
  parameter int N_ADDERS = N - 1,
  parameter int SELW     = 6 * N_ADDERS,
  parameter int CFGW     = 2 * N_ADDERS + SELW,
  parameter int N_CFG    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_addr,
  input  logic [CFGW-1:0]               cfg_wdata,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [1:0]                    job_cfg,
  input  logic [7:0]                    job_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW_DATA*N-1:0]          in_data,
  output logic [N_ADDERS-1:0]           tree_add_en,
  output logic [N_ADDERS-1:0]           tree_bypass_en,
  output logic [SELW-1:0]               tree_sel,
  output logic [DW_DATA*N-1:0]          tree_in,
  input  logic [DW_DATA*2*N_ADDERS-1:0] tree_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DW_DATA*2*N_ADDERS-1:0] out_data,
  output logic                          out_last,
  output logic                          busy
);
  import fan_ctrl_pkg::*;
  localparam int BYP = byp_off(N_ADDERS);
  localparam int SEL = sel_off(N_ADDERS);
  localparam int OW  = DW_DATA * 2 * N_ADDERS;
  state_e state_q, state_d;
  logic init_q;
  logic [CFGW-1:0] cfg_q, cfg_d, tbl_rdata;
  logic [8:0] cnt_q, cnt_d;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW_DATA*N-1:0] tree_in_q, tree_in_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic job_hs, in_hs, s1_adv, out_hs;
  fan_cfg_table #(.W(CFGW)) u_tbl (
    .clk(clk),
    .rst(rst),
    .we_i(cfg_we),
    .waddr_i(cfg_addr),
    .wdata_i(cfg_wdata),
    .raddr_i(job_cfg),
    .rdata_o(tbl_rdata)
  );
  // init_q keeps job_ready low for the first cycle after reset release
  assign job_ready = init_q && state_q == IDLE;
  assign s1_adv    = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = state_q == RUN && cnt_q != '0 && (!s1_valid_q || s1_adv);
  assign job_hs    = job_valid && job_ready;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign busy      = state_q != IDLE;
  assign tree_add_en    = cfg_q[ADD_OFF +: N_ADDERS];
  assign tree_bypass_en = cfg_q[BYP +: N_ADDERS];
  assign tree_sel       = cfg_q[SEL +: SELW];
  assign tree_in   = tree_in_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    cnt_d      = cnt_q;
    tree_in_d  = tree_in_q;
    s1_last_d  = s1_last_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (job_hs) begin
      state_d = RUN;
      cfg_d   = tbl_rdata;
      cnt_d   = {job_len == 8'd0, job_len};
    end
    if (in_hs) begin
      tree_in_d = in_data;
      s1_last_d = cnt_q == 9'd1;
      cnt_d     = cnt_q - 9'd1;
      state_d   = (cnt_q == 9'd1) ? DRAIN : state_q;
    end
    s1_valid_d  = in_hs || (s1_valid_q && !s1_adv);
    out_valid_d = s1_adv || (out_valid_q && !out_ready);
    if (s1_adv) begin
      out_data_d = tree_out;
      out_last_d = s1_last_q;
    end else if (out_hs) out_last_d = 1'b0;
    if (state_q == DRAIN && out_hs && out_last_q) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      init_q      <= 1'b0;
      cfg_q       <= '0;
      cnt_q       <= '0;
      tree_in_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= 1'b1;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      tree_in_q   <= tree_in_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
endmodule

// File: tb/tb_fan_ctrl.sv
// tb_fan_ctrl: directed bench for fan_ctrl with a 4-leaf reference tree
module tb_fan_ctrl;
  localparam int N = 4, DW = 8, NA = 3, SELW = 18, CFGW = 24, OW = 48;
  typedef struct packed {logic rdy; logic last; logic [OW-1:0] data; logic [31:0] cyc;} ob_t;
  logic clk = 0, rst = 1, cfg_we = 0, job_valid = 0, in_valid = 0, out_ready = 1;
  logic [1:0] cfg_addr = 0, job_cfg = 0;
  logic [CFGW-1:0] cfg_wdata = 0;
  logic [7:0] job_len = 0;
  logic [DW*N-1:0] in_data = 0, tree_in;
  logic job_ready, in_ready, out_valid, out_last, busy;
  logic [NA-1:0] tree_add_en, tree_bypass_en;
  logic [SELW-1:0] tree_sel;
  logic [OW-1:0] tree_out, out_data;
  int checks = 0, errors = 0, cyc = 0, in_rd = 0, ob_rd = 0;
  logic [31:0] inq[$];
  int incyc[$];
  ob_t obs[$];
  always #5 clk = ~clk;
  fan_ctrl #(.N(N), .DW_DATA(DW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tree_add_en(tree_add_en), .tree_bypass_en(tree_bypass_en), .tree_sel(tree_sel),
    .tree_in(tree_in), .tree_out(tree_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );
  function automatic logic [OW-1:0] tree_f(input logic [CFGW-1:0] c, input logic [31:0] v);
    logic [15:0] a0, a1, a2;
    a0 = c[0] ? 16'(v[7:0]) + 16'(v[15:8]) : c[3] ? 16'(v[7:0]) : 16'd0;
    a1 = c[1] ? 16'(v[23:16]) + 16'(v[31:24]) : c[4] ? 16'(v[23:16]) : 16'd0;
    a2 = c[2] ? a0 + a1 : c[5] ? a0 : 16'd0;
    return {a2, a1, a0} ^ {c[23:8], 32'd0};
  endfunction
  assign tree_out = tree_f({tree_sel, tree_bypass_en, tree_add_en}, tree_in);
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst) begin
      if (out_valid) obs.push_back('{rdy: out_ready, last: out_last, data: out_data, cyc: cyc});
      if (in_valid && in_ready) begin
        inq.push_back(in_data);
        incyc.push_back(cyc);
      end
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [CFGW-1:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick;
    cfg_we = 0;
  endtask
  task automatic job(input logic [1:0] c, input logic [7:0] l);
    int t = 0;
    job_valid = 1; job_cfg = c; job_len = l;
    while (!job_ready && t < 100) begin tick; t++; end
    chk("job_rdy", 64'(job_ready), 64'(1));
    tick;
    job_valid = 0;
  endtask
  task automatic send(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1; in_data = $urandom; t = 0;
      #1;
      while (!in_ready && t < 200) begin tick; #1; t++; end
      if (t >= 200) chk("in_tmo", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 0;
  endtask
  task automatic wait_idle;
    int t = 0;
    while (busy && t < 1000) begin tick; t++; end
    chk("idle", 64'(busy), 64'(0));
    tick;
  endtask
  task automatic score(input string tag, input int nv, input logic [CFGW-1:0] c);
    int k = 0, nh = 0;
    ob_t o;
    chk({tag, "_nin"}, 64'(inq.size() - in_rd), 64'(nv));
    while (ob_rd < obs.size()) begin
      o = obs[ob_rd]; ob_rd++;
      if (k < nv && in_rd + k < inq.size()) begin
        chk({tag, "_d"}, 64'(o.data), 64'(tree_f(c, inq[in_rd + k])));
        chk({tag, "_l"}, 64'(o.last), 64'(k == nv - 1));
        if (o.rdy) k++;
      end
      if (o.rdy) nh++;
    end
    chk({tag, "_nout"}, 64'(nh), 64'(nv));
    in_rd = inq.size();
  endtask
  localparam logic [CFGW-1:0] C1 = {18'h25A5A, 3'b000, 3'b111};
  localparam logic [CFGW-1:0] C0 = {18'h08421, 3'b011, 3'b100};
  localparam logic [CFGW-1:0] C3 = {18'h01234, 3'b001, 3'b110};
  localparam logic [CFGW-1:0] CA = {18'h30F0F, 3'b010, 3'b101};
  localparam logic [CFGW-1:0] CB = {18'h000FF, 3'b100, 3'b011};
  localparam logic [CFGW-1:0] CC = {18'h11111, 3'b111, 3'b000};
  initial begin
    int b, o0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_jr", 64'(job_ready), 64'(0));
    chk("rst_ir", 64'(in_ready), 64'(0));
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_ol", 64'(out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cfg", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(0));
    chk("rst_tin", 64'(tree_in), 64'(0));
    chk("rst_od", 64'(out_data), 64'(0));
    rst = 0;
    #1 chk("jr_rel", 64'(job_ready), 64'(0));
    tick;
    chk("jr_up", 64'(job_ready), 64'(1));
    wr(1, C1);
    b = inq.size(); o0 = ob_rd;
    job(1, 3);
    chk("t1_cfg", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(C1));
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_jr", 64'(job_ready), 64'(0));
    send(3);
    wait_idle;
    chk("t1_lat", 64'(int'(obs[o0].cyc) - incyc[b]), 64'(2));
    chk("t1_thr", 64'(int'(obs[o0+2].cyc) - int'(obs[o0].cyc)), 64'(2));
    score("t1", 3, C1);
    chk("t1_jr2", 64'(job_ready), 64'(1));
    wr(0, C0);
    job(0, 0);
    send(256);
    #1 chk("t2_ir", 64'(in_ready), 64'(0));
    wait_idle;
    score("t2", 256, C0);
    wr(3, C3);
    job(3, 8);
    fork
      send(8);
      begin
        repeat (2) tick;
        out_ready = 0;
        repeat (5) tick;
        chk("t3_ir", 64'(in_ready), 64'(0));
        chk("t3_ov", 64'(out_valid), 64'(1));
        out_ready = 1;
      end
    join
    wait_idle;
    score("t3", 8, C3);
    wr(2, CA);
    cfg_we = 1; cfg_addr = 2; cfg_wdata = CB;
    job(2, 2);
    cfg_we = 0;
    chk("t4_cfg", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(CA));
    send(2);
    wait_idle;
    score("t4", 2, CA);
    job(2, 2);
    chk("t5_cfg0", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(CB));
    wr(2, CC);
    chk("t5_cfg1", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(CB));
    send(2);
    chk("t5_cfg2", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(CB));
    wait_idle;
    score("t5", 2, CB);
    job(2, 1);
    chk("t5_cfg3", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(CC));
    send(1);
    wait_idle;
    score("t5b", 1, CC);
    job(1, 10);
    send(2);
    chk("t6_fl", 64'(out_valid), 64'(1));
    rst = 1;
    #1;
    chk("t6_ov", 64'(out_valid), 64'(0));
    chk("t6_ol", 64'(out_last), 64'(0));
    chk("t6_ir", 64'(in_ready), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_jr", 64'(job_ready), 64'(0));
    chk("t6_cfg", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(0));
    chk("t6_tin", 64'(tree_in), 64'(0));
    chk("t6_od", 64'(out_data), 64'(0));
    tick;
    rst = 0;
    in_rd = inq.size(); ob_rd = obs.size();
    repeat (3) tick;
    chk("t6_nov", 64'(obs.size() - ob_rd), 64'(0));
    job(1, 2);
    chk("t6_tbl", 64'({tree_sel, tree_bypass_en, tree_add_en}), 64'(0));
    send(2);
    wait_idle;
    score("t6", 2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/fan_ctrl.md
FAN_CTRL -- requirements
Module: fan_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, number of tree leaf inputs (power of two).
REQ-002 SHALL have parameter DW_DATA, default 8, element width.
REQ-003 SHALL have parameter N_ADDERS = N-1, SELW = 6*N_ADDERS, CFGW = 2*N_ADDERS+SELW, N_CFG = 4.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have: rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have: cfg_we in 1, cfg_addr in 2, cfg_wdata in CFGW ({sel, bypass_en, add_en}, add_en in LSBs); writes one config table entry.
REQ-007 SHALL have: job_valid in 1, job_ready out 1, job_cfg in 2, job_len in 8; one job = job_len vectors, with 0 meaning 256.
REQ-008 SHALL have: in_valid in 1, in_ready out 1, in_data in DW_DATA*N; input vector stream.
REQ-009 SHALL have: tree_add_en out N_ADDERS, tree_bypass_en out N_ADDERS, tree_sel out SELW, tree_in out DW_DATA*N; these drive the combinational reduction tree.
REQ-010 SHALL have: tree_out in DW_DATA*2*N_ADDERS; the tree result.
REQ-011 SHALL have: out_valid out 1, out_ready in 1, out_data out DW_DATA*2*N_ADDERS, out_last out 1.
REQ-012 SHALL have: busy out 1, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-014 In IDLE, SHALL assert job_ready; on job_valid, SHALL copy table[job_cfg] into the active-config register, load the remaining-count register with job_len (0 -> 256), and go to RUN.
REQ-015 The active config SHALL drive tree_add_en/tree_bypass_en/tree_sel and stay constant from job accept until return to IDLE.
REQ-016 Table writes SHALL take effect the next cycle. A write in the same cycle as a job accept to the same index SHALL leave the job with the old entry. Writes during RUN/DRAIN SHALL affect only later jobs.
REQ-017 Stage 1: in RUN, in_ready = !s1_valid || s1_advance. On an in_valid&&in_ready handshake, SHALL register in_data into tree_in, set s1_valid, and decrement the remaining count.
REQ-018 Stage 2: s1_advance = s1_valid && (!out_valid || out_ready). On advance, SHALL register tree_out into out_data, set out_valid, and set out_last if the vector is the job's final one.
REQ-019 Latency SHALL be 2 cycles from input handshake to out_valid with no backpressure; sustained throughput SHALL be 1 vector/cycle.
REQ-020 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-021 When the final vector is accepted, SHALL deassert in_ready and enter DRAIN. DRAIN SHALL exit to IDLE after the out_last handshake completes, then accept a new job the next cycle.
REQ-022 in_ready SHALL be 0 in IDLE and DRAIN, and job_ready SHALL be 0 outside IDLE.
REQ-023 The remaining count SHALL be 9 bits wide and SHALL never wrap; in_ready SHALL be 0 when the count is 0.

Reset
REQ-024 On rst, SHALL be in IDLE with all of the following zero: job_ready deasserted then asserted one cycle after reset release, in_ready, out_valid, out_last, s1_valid, busy, tree_add_en, tree_bypass_en, tree_sel, tree_in, out_data, remaining count, and all table entries.
REQ-025 Reset mid-job SHALL abort the job with no further out_valid; no partial state SHALL survive.

Structure
REQ-026 A shared package SHALL hold the N, N_ADDERS, SELW and CFGW constants, the FSM state enum, and the config-entry field offsets.
REQ-027 The config table SHALL be a single sub-module fan_cfg_table (4 x CFGW, 1 write port, 1 asynchronous read port).
REQ-028 fan_ctrl SHALL NOT instantiate the tree; the integration level connects the tree_* ports.

Verification
REQ-029 Write entry 1 with add_en = all ones, then job cfg=1 len=3 with 3 back-to-back vectors and out_ready=1 -> out_valid on cycles 2, 3, 4 after the first handshake, out_last only on the third, busy low afterward.
REQ-030 job_len=0 -> exactly 256 outputs, out_last on the 256th, in_ready low after 256 accepts.
REQ-031 Hold out_ready=0 for 5 cycles mid-job -> out_data stable, in_ready drops once stage 1 is full, no vector lost or duplicated; out_data matches a reference-tree model.
REQ-032 cfg_we to entry 2 in the job-accept cycle for cfg=2 -> the job uses the old entry 2, and the next job uses the new one.
REQ-033 Assert rst during RUN with 2 vectors in flight -> all outputs 0 the same cycle; after release, a new job runs correctly.
REQ-034 Table write during RUN to the active index -> tree_* outputs unchanged until IDLE.
